y86_cc_unit: RTL and testbench
==============================

# y86_cc_unit

Condition-code register and condition evaluator for the pipelined Y86 core. It sits beside the execute-stage ALU and captures the ALU's zero, signed and overflow flags after each OPl instruction. It evaluates jXX and cmovXX conditions against the stored codes and carries the branch outcome into the memory-stage register. From there it raises the mispredict signal that redirects fetch.

## Interface
Parameters: none.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- E_icode  in  4  execute-stage icode
- E_ifunc  in  4  execute-stage ifunc (condition selector for jXX/cmovXX)
- E_dstE  in  4  execute-stage destination register for valE
- E_valA  in  32  execute-stage valA (fall-through PC for jXX)
- zero_flag, signed_flag, overflow_flag  in  1 each  combinational ALU flags for the instruction in E
- m_exc  in  1  memory stage currently holds an exception (stat != AOK)
- W_exc  in  1  writeback stage holds an exception
- M_bubble  in  1  load a bubble into the M register this edge
- cc_zf, cc_sf, cc_of  out  1 each  stored condition codes
- e_Cnd  out  1  condition result for the instruction in E (combinational)
- e_dstE  out  4  E_dstE, forced to 4'hF when a cmovXX is not taken
- M_icode  out  4  registered icode
- M_Cnd  out  1  registered e_Cnd
- M_valA  out  32  registered E_valA
- mispredict  out  1  M_icode == 4'h7 && !M_Cnd (combinational from registers)

## Operation
- set_cc = (E_icode == 4'h6) && !m_exc && !W_exc.
- On each edge with set_cc true, {cc_zf, cc_sf, cc_of} ← {zero_flag, signed_flag, overflow_flag}. Otherwise the codes hold.
- Condition function, indexed by E_ifunc, uses the stored codes:
  - 0: 1
  - 1 (le): (SF^OF)|ZF
  - 2 (l): SF^OF
  - 3 (e): ZF
  - 4 (ne): !ZF
  - 5 (ge): !(SF^OF)
  - 6 (g): !(SF^OF)&!ZF
  - 7–F: 0
- e_Cnd = cond(E_ifunc) when E_icode is 4'h2 (rrmovl/cmovXX) or 4'h7 (jXX), else 0.
- e_dstE = 4'hF when E_icode == 4'h2 && !e_Cnd, else E_dstE. An unconditional rrmovl (ifunc 0) always passes E_dstE.
- M register:
  - Normal edge: {M_icode, M_Cnd, M_valA} ← {E_icode, e_Cnd, E_valA}.
  - Edge with M_bubble = 1: the register loads NOP, i.e. {4'h1, 0, 32'h0}.
- The OPl in E does not forward its own flags to e_Cnd. A jXX or cmovXX in E always sees codes written at or before the previous edge. With one-instruction spacing this is architecturally correct.

## Timing
- Reset (asynchronous, reset = 0), held while asserted:
  - cc_zf = 1, cc_sf = 0, cc_of = 0
  - M_icode = 4'h1, M_Cnd = 0, M_valA = 0, mispredict = 0
- Reset release: first update on the next rising edge after reset = 1.
- CC latency: flags presented in cycle N with set_cc become visible on cc_* and in e_Cnd from cycle N+1.
- e_Cnd and e_dstE: zero-cycle combinational from E inputs and cc_*.
- mispredict: asserted in the cycle after the jXX leaves E, for exactly one cycle unless repeated.
- Simultaneous events:
  - set_cc with m_exc or W_exc: codes do not change.
  - M_bubble with a jXX in E: the bubble wins, and mispredict is 0 next cycle.
- Reset mid-operation immediately clears all state as above, regardless of clk.

## Structure
- Shared package y86_pkg holds:
  - icode constants: NOP 4'h1, RRMOVL/CMOVXX 4'h2, OPL 4'h6, JXX 4'h7
  - condition selectors C_YES…C_G (0–6)
  - RNONE 4'hF
  - the NOP bubble value
- One combinational sub-module, y86_cond_eval (ifunc, zf, sf, of → cnd), is natural. Reuse it wherever the core evaluates conditions.
- The top holds the CC register, the M register and the gating logic.

## Test plan
- Reset: assert reset = 0 mid-run → cc_zf = 1, cc_sf = 0, cc_of = 0, M_icode = 1, mispredict = 0 immediately (no clock).
- subl equal then je: E_icode = 6 with zero_flag = 1 → next cycle cc_zf = 1. Then E_icode = 7, E_ifunc = 3 → e_Cnd = 1, next cycle M_Cnd = 1, mispredict = 0.
- jl with overflow: cc_sf = 1, cc_of = 1 latched, then E_icode = 7, E_ifunc = 2 → e_Cnd = 0. Next cycle mispredict = 1 and M_valA = the driven E_valA (e.g. 32'h0000_0040).
- Exception blocking: E_icode = 6, zero_flag = 0, signed_flag = 1, with m_exc = 1 → cc_* unchanged after the edge. Repeat with W_exc = 1 → same result.
- cmov not taken: cc_zf = 0, E_icode = 2, E_ifunc = 3, E_dstE = 4'h3 → e_dstE = 4'hF. With E_ifunc = 0 → e_dstE = 4'h3.
- Bubble: not-taken jXX in E with M_bubble = 1 → next cycle M_icode = 1, M_Cnd = 0, mispredict = 0. Sweep E_ifunc = 7–F with E_icode = 7 → e_Cnd = 0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 pipeline constants: icodes, condition selectors, register ids
// and the memory-stage pipeline register layout with its bubble value.
package y86_pkg;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVL = 4'h2;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [3:0]  icode;
    logic        cnd;
    logic [31:0] valA;
  } mreg_t;

  localparam mreg_t M_NOP = '{icode: I_NOP, cnd: 1'b0, valA: 32'h0};

endpackage

// File: rtl/y86_cond_eval.sv
// Combinational jXX/cmovXX condition evaluator over stored condition codes.
module y86_cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifunc,
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  output logic       cnd
);

  logic lt;

  assign lt = sf ^ of;

  // Selectors 7..F are undefined conditions and never fire.
  always_comb begin
    cnd = 1'b0;
    case (ifunc)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = lt | zf;
      C_L:     cnd = lt;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~lt;
      C_G:     cnd = ~lt & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/y86_cc_unit.sv
// Condition-code register, execute-stage condition gating and the
// memory-stage register that produces the branch mispredict redirect.
module y86_cc_unit
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_ifunc,
  input  logic [3:0]  E_dstE,
  input  logic [31:0] E_valA,
  input  logic        zero_flag,
  input  logic        signed_flag,
  input  logic        overflow_flag,
  input  logic        m_exc,
  input  logic        W_exc,
  input  logic        M_bubble,
  output logic        cc_zf,
  output logic        cc_sf,
  output logic        cc_of,
  output logic        e_Cnd,
  output logic [3:0]  e_dstE,
  output logic [3:0]  M_icode,
  output logic        M_Cnd,
  output logic [31:0] M_valA,
  output logic        mispredict
);

  logic [2:0] cc_q, cc_d;
  mreg_t      m_q, m_d;
  logic       set_cc;
  logic       cond_ok;

  // A faulting instruction further down the pipe must not leave its
  // side effects behind, so younger OPl results are discarded.
  assign set_cc = (E_icode == I_OPL) && !m_exc && !W_exc;
  assign cc_d   = set_cc ? {zero_flag, signed_flag, overflow_flag} : cc_q;

  assign {cc_zf, cc_sf, cc_of} = cc_q;

  y86_cond_eval u_cond (
    .ifunc (E_ifunc),
    .zf    (cc_zf),
    .sf    (cc_sf),
    .of    (cc_of),
    .cnd   (cond_ok)
  );

  assign e_Cnd  = ((E_icode == I_RRMOVL) || (E_icode == I_JXX)) && cond_ok;
  assign e_dstE = ((E_icode == I_RRMOVL) && !e_Cnd) ? RNONE : E_dstE;

  always_comb begin
    m_d = '{icode: E_icode, cnd: e_Cnd, valA: E_valA};
    if (M_bubble) m_d = M_NOP;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cc_q <= 3'b100;
      m_q  <= M_NOP;
    end else begin
      cc_q <= cc_d;
      m_q  <= m_d;
    end
  end

  assign M_icode    = m_q.icode;
  assign M_Cnd      = m_q.cnd;
  assign M_valA     = m_q.valA;
  assign mispredict = (m_q.icode == I_JXX) && !m_q.cnd;

endmodule

// File: tb/tb_y86_cc_unit.sv
// Directed bench for y86_cc_unit: reset values, flag capture, condition
// evaluation, exception blocking, cmov gating, bubbles and async reset.
module tb_y86_cc_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  E_icode;
  logic [3:0]  E_ifunc;
  logic [3:0]  E_dstE;
  logic [31:0] E_valA;
  logic        zero_flag;
  logic        signed_flag;
  logic        overflow_flag;
  logic        m_exc;
  logic        W_exc;
  logic        M_bubble;
  logic        cc_zf;
  logic        cc_sf;
  logic        cc_of;
  logic        e_Cnd;
  logic [3:0]  e_dstE;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [31:0] M_valA;
  logic        mispredict;

  int total = 0;
  int bad   = 0;

  y86_cc_unit dut (
    .clk           (clk),
    .reset         (reset),
    .E_icode       (E_icode),
    .E_ifunc       (E_ifunc),
    .E_dstE        (E_dstE),
    .E_valA        (E_valA),
    .zero_flag     (zero_flag),
    .signed_flag   (signed_flag),
    .overflow_flag (overflow_flag),
    .m_exc         (m_exc),
    .W_exc         (W_exc),
    .M_bubble      (M_bubble),
    .cc_zf         (cc_zf),
    .cc_sf         (cc_sf),
    .cc_of         (cc_of),
    .e_Cnd         (e_Cnd),
    .e_dstE        (e_dstE),
    .M_icode       (M_icode),
    .M_Cnd         (M_Cnd),
    .M_valA        (M_valA),
    .mispredict    (mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle a little past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] icode, input logic [3:0] ifunc,
                               input logic [3:0] dst, input logic [31:0] vala,
                               input logic zf, input logic sf, input logic of);
    E_icode       = icode;
    E_ifunc       = ifunc;
    E_dstE        = dst;
    E_valA        = vala;
    zero_flag     = zf;
    signed_flag   = sf;
    overflow_flag = of;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    m_exc = 1'b0;
    W_exc = 1'b0;
    M_bubble = 1'b0;
    applyStimulus(4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("rst_cc", {29'h0, cc_zf, cc_sf, cc_of}, 32'h4);
    checkOutput("rst_M_icode", {28'h0, M_icode}, 32'h1);
    checkOutput("rst_M_Cnd", {31'h0, M_Cnd}, 32'h0);
    checkOutput("rst_M_valA", M_valA, 32'h0);
    checkOutput("rst_mispredict", {31'h0, mispredict}, 32'h0);
    reset = 1'b1;

    // OPl clearing ZF, then OPl setting ZF (subl equal)
    applyStimulus(4'h6, 4'h1, 4'h2, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("opl_no_cnd", {31'h0, e_Cnd}, 32'h0);
    step();
    checkOutput("cc_zf_cleared", {29'h0, cc_zf, cc_sf, cc_of}, 32'h0);
    applyStimulus(4'h6, 4'h1, 4'h2, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("cc_zf_set", {29'h0, cc_zf, cc_sf, cc_of}, 32'h4);

    // je taken
    applyStimulus(4'h7, 4'h3, 4'hF, 32'h10, 1'b0, 1'b0, 1'b0);
    checkOutput("je_e_Cnd", {31'h0, e_Cnd}, 32'h1);
    step();
    checkOutput("je_M_Cnd", {31'h0, M_Cnd}, 32'h1);
    checkOutput("je_M_icode", {28'h0, M_icode}, 32'h7);
    checkOutput("je_mispredict", {31'h0, mispredict}, 32'h0);

    // SF=1, OF=1 latched; jl not taken -> mispredict
    applyStimulus(4'h6, 4'h1, 4'h2, 32'h0, 1'b0, 1'b1, 1'b1);
    step();
    checkOutput("cc_sf_of", {29'h0, cc_zf, cc_sf, cc_of}, 32'h3);
    applyStimulus(4'h7, 4'h2, 4'hF, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
    checkOutput("jl_e_Cnd", {31'h0, e_Cnd}, 32'h0);
    applyStimulus(4'h7, 4'h1, 4'hF, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
    checkOutput("jle_e_Cnd", {31'h0, e_Cnd}, 32'h0);
    applyStimulus(4'h7, 4'h5, 4'hF, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
    checkOutput("jge_e_Cnd", {31'h0, e_Cnd}, 32'h1);
    applyStimulus(4'h7, 4'h6, 4'hF, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
    checkOutput("jg_e_Cnd", {31'h0, e_Cnd}, 32'h1);
    applyStimulus(4'h7, 4'h2, 4'hF, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("jl_mispredict", {31'h0, mispredict}, 32'h1);
    checkOutput("jl_M_valA", M_valA, 32'h0000_0040);
    applyStimulus(4'h1, 4'h0, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("mispredict_one_cycle", {31'h0, mispredict}, 32'h0);

    // Exceptions downstream block CC updates
    m_exc = 1'b1;
    applyStimulus(4'h6, 4'h1, 4'h2, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("m_exc_block", {29'h0, cc_zf, cc_sf, cc_of}, 32'h3);
    m_exc = 1'b0;
    W_exc = 1'b1;
    applyStimulus(4'h6, 4'h1, 4'h2, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("W_exc_block", {29'h0, cc_zf, cc_sf, cc_of}, 32'h3);
    W_exc = 1'b0;

    // cmov gating with ZF=0
    applyStimulus(4'h2, 4'h3, 4'h3, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("cmove_dstE", {28'h0, e_dstE}, 32'hF);
    checkOutput("cmove_e_Cnd", {31'h0, e_Cnd}, 32'h0);
    applyStimulus(4'h2, 4'h0, 4'h3, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("rrmovl_dstE", {28'h0, e_dstE}, 32'h3);
    applyStimulus(4'h2, 4'h4, 4'h3, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("cmovne_dstE", {28'h0, e_dstE}, 32'h3);
    applyStimulus(4'h6, 4'h3, 4'h3, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("opl_dstE_pass", {28'h0, e_dstE}, 32'h3);
    step();

    // Bubble overrides a not-taken jXX (cc now 000 -> je not taken)
    M_bubble = 1'b1;
    applyStimulus(4'h7, 4'h3, 4'hF, 32'h0000_0099, 1'b0, 1'b0, 1'b0);
    step();
    M_bubble = 1'b0;
    checkOutput("bubble_M_icode", {28'h0, M_icode}, 32'h1);
    checkOutput("bubble_M_Cnd", {31'h0, M_Cnd}, 32'h0);
    checkOutput("bubble_M_valA", M_valA, 32'h0);
    checkOutput("bubble_mispredict", {31'h0, mispredict}, 32'h0);
    for (int f = 7; f < 16; f++) begin
      applyStimulus(4'h7, f[3:0], 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("undef_ifunc_%0h", f), {31'h0, e_Cnd}, 32'h0);
    end

    // cc = (ZF=0, SF=1, OF=0): less-than conditions true
    applyStimulus(4'h6, 4'h1, 4'h2, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(4'h7, 4'h2, 4'hF, 32'h80, 1'b0, 1'b0, 1'b0);
    checkOutput("jl_taken", {31'h0, e_Cnd}, 32'h1);
    applyStimulus(4'h7, 4'h6, 4'hF, 32'h80, 1'b0, 1'b0, 1'b0);
    checkOutput("jg_not_taken", {31'h0, e_Cnd}, 32'h0);
    applyStimulus(4'h7, 4'h3, 4'hF, 32'h80, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("pre_reset_mispredict", {31'h0, mispredict}, 32'h1);

    // Asynchronous reset mid-cycle, away from any clock edge
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_cc", {29'h0, cc_zf, cc_sf, cc_of}, 32'h4);
    checkOutput("async_M_icode", {28'h0, M_icode}, 32'h1);
    checkOutput("async_M_valA", M_valA, 32'h0);
    checkOutput("async_mispredict", {31'h0, mispredict}, 32'h0);
    step();
    reset = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
